// File: rtl/pipe_pkg.sv
// Shared fetch-scheduler types and defaults.
// Imported by every pipeline control file.
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEF     = 32'h0001_0000;
  localparam int          FLUSH_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    BUBBLE = 2'd2,
    FLUSH  = 2'd3
  } fs_state_e;

  typedef struct packed {
    logic        vld;
    logic        late;
    logic [31:0] pc;
  } redir_t;

  // A late (older) branch beats any early one; otherwise newest wins.
  function automatic redir_t merge_redir(
    redir_t old_r,
    redir_t new_r
  );
    if (new_r.late || (new_r.vld && !old_r.late))
      return new_r;
    return old_r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator between EX load and fetched sources.
// Purely combinational; x0 never causes a hazard.
module hazard_detect (
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] if_rs1,
  input  logic [4:0] if_rs2,
  output logic       hit
);

  assign hit = ex_is_load && (ex_rd != 5'd0) &&
               ((ex_rd == if_rs1) || (ex_rd == if_rs2));

endmodule

// File: rtl/fetch_sched.sv
// Fetch scheduler: redirects, flushes, load-use bubbles, waits.
// All outputs registered; decisions land one edge after sampling.
module fetch_sched
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter int          FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iready_n,
  input  logic        br_early_req,
  input  logic [31:0] br_early_pc,
  input  logic        br_late_req,
  input  logic [31:0] br_late_pc,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  if_rs1,
  input  logic [4:0]  if_rs2,
  output logic        keep,
  output logic        nop,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic [15:0] stall_cnt
);

  localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);

  fs_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  redir_t      pend_q, pend_d;
  redir_t      req, merged;
  logic        keep_d, nop_d, rv_d;
  logic [31:0] rpc_d;
  logic        hit;

  hazard_detect u_hz (
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .if_rs1     (if_rs1),
    .if_rs2     (if_rs2),
    .hit        (hit)
  );

  // Current-cycle redirect request, late over early.
  always_comb begin
    req      = '0;
    req.vld  = br_late_req | br_early_req;
    req.late = br_late_req;
    req.pc   = br_late_req ? br_late_pc : br_early_pc;
    merged   = merge_redir(pend_q, req);
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    keep_d  = 1'b0;
    nop_d   = 1'b0;
    rv_d    = 1'b0;
    rpc_d   = redir_pc;
    unique case (state_q)
      RUN, BUBBLE: begin
        if (iready_n) begin
          state_d = WAIT;
          keep_d  = 1'b1;
          nop_d   = 1'b1;
          pend_d  = req;
        end else if (req.vld) begin
          state_d = FLUSH;
          cnt_d   = FL_LOAD;
          rv_d    = 1'b1;
          rpc_d   = req.pc;
          nop_d   = 1'b1;
        end else if (hit && state_q == RUN) begin
          state_d = BUBBLE;
          keep_d  = 1'b1;
          nop_d   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      WAIT: begin
        if (iready_n) begin
          keep_d = 1'b1;
          nop_d  = 1'b1;
          pend_d = merged;
        end else if (merged.vld) begin
          state_d = FLUSH;
          cnt_d   = FL_LOAD;
          rv_d    = 1'b1;
          rpc_d   = merged.pc;
          nop_d   = 1'b1;
          pend_d  = '0;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (iready_n) begin
          keep_d = 1'b1;
          nop_d  = 1'b1;
          if (req.vld) begin
            state_d = WAIT;
            pend_d  = req;
          end
        end else if (req.vld) begin
          cnt_d = FL_LOAD;
          rv_d  = 1'b1;
          rpc_d = req.pc;
          nop_d = 1'b1;
        end else if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
          nop_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, pending redirect and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      pend_q      <= '0;
      keep        <= 1'b0;
      nop         <= 1'b1;
      redir_valid <= 1'b0;
      redir_pc    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      keep        <= keep_d;
      nop         <= nop_d;
      redir_valid <= rv_d;
      redir_pc    <= rpc_d;
    end
  end

  // Saturating count of cycles spent with keep asserted.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (keep_d && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fetch_sched.sv
// Directed bench for fetch_sched.
// Expected values computed by hand from the cycle behaviour.
module tb_fetch_sched;

  logic        clk;
  logic        rst;
  logic        iready_n;
  logic        br_early_req;
  logic [31:0] br_early_pc;
  logic        br_late_req;
  logic [31:0] br_late_pc;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [4:0]  if_rs1;
  logic [4:0]  if_rs2;
  logic        keep;
  logic        nop;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [15:0] stall_cnt;

  int n_chk;
  int n_pass;

  fetch_sched dut (
    .clk          (clk),
    .rst          (rst),
    .iready_n     (iready_n),
    .br_early_req (br_early_req),
    .br_early_pc  (br_early_pc),
    .br_late_req  (br_late_req),
    .br_late_pc   (br_late_pc),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .if_rs1       (if_rs1),
    .if_rs2       (if_rs2),
    .keep         (keep),
    .nop          (nop),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    br_early_req = 1'b0;
    br_late_req  = 1'b0;
    ex_is_load   = 1'b0;
    ex_rd        = 5'd0;
    if_rs1       = 5'd0;
    if_rs2       = 5'd0;
    iready_n     = 1'b0;
  endtask

  task automatic outs(
    input string       tag,
    input logic        k,
    input logic        n,
    input logic        rv
  );
    chk({tag, ".keep"}, {31'd0, keep}, {31'd0, k});
    chk({tag, ".nop"}, {31'd0, nop}, {31'd0, n});
    chk({tag, ".rv"}, {31'd0, redir_valid}, {31'd0, rv});
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    br_early_pc = 32'h0;
    br_late_pc = 32'h0;
    clr();

    for (int i = 0; i < 3; i++) begin
      step();
      outs("rst", 1'b0, 1'b1, 1'b0);
      chk("rst.pc", redir_pc, 32'h0001_0000);
      chk("rst.stall", {16'd0, stall_cnt}, 32'd0);
    end
    rst = 1'b0;
    step();
    outs("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst.pc", redir_pc, 32'h0001_0000);

    br_early_req = 1'b1;
    br_early_pc = 32'h0001_0040;
    step();
    outs("early", 1'b0, 1'b1, 1'b1);
    chk("early.pc", redir_pc, 32'h0001_0040);
    clr();
    step();
    outs("early.fl1", 1'b0, 1'b1, 1'b0);
    step();
    outs("early.run", 1'b0, 1'b0, 1'b0);

    br_early_req = 1'b1;
    br_early_pc = 32'h0000_0100;
    br_late_req = 1'b1;
    br_late_pc = 32'h0000_0200;
    step();
    outs("both", 1'b0, 1'b1, 1'b1);
    chk("both.pc", redir_pc, 32'h0000_0200);
    clr();
    step();
    step();
    outs("both.run", 1'b0, 1'b0, 1'b0);

    ex_is_load = 1'b1;
    ex_rd = 5'd5;
    if_rs2 = 5'd5;
    step();
    outs("lu", 1'b1, 1'b1, 1'b0);
    chk("lu.stall", {16'd0, stall_cnt}, 32'd1);
    step();
    outs("lu.once", 1'b0, 1'b0, 1'b0);
    clr();
    ex_is_load = 1'b1;
    step();
    outs("lu.x0", 1'b0, 1'b0, 1'b0);
    chk("lu.x0.stall", {16'd0, stall_cnt}, 32'd1);

    ex_rd = 5'd7;
    if_rs1 = 5'd7;
    br_early_req = 1'b1;
    br_early_pc = 32'h0000_0500;
    step();
    outs("lu_br", 1'b0, 1'b1, 1'b1);
    chk("lu_br.pc", redir_pc, 32'h0000_0500);
    clr();
    step();
    step();
    outs("lu_br.run", 1'b0, 1'b0, 1'b0);
    chk("lu_br.stall", {16'd0, stall_cnt}, 32'd1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2.stall", {16'd0, stall_cnt}, 32'd0);
    br_late_pc = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      iready_n = 1'b1;
      br_late_req = (i == 1);
      step();
      outs("wait", 1'b1, 1'b1, 1'b0);
    end
    clr();
    step();
    outs("wait.exit", 1'b0, 1'b1, 1'b1);
    chk("wait.pc", redir_pc, 32'h0000_0300);
    chk("wait.stall", {16'd0, stall_cnt}, 32'd4);
    step();
    step();
    outs("wait.run", 1'b0, 1'b0, 1'b0);

    iready_n = 1'b1;
    br_late_req = 1'b1;
    br_late_pc = 32'h0000_0400;
    step();
    br_late_req = 1'b0;
    br_early_req = 1'b1;
    br_early_pc = 32'h0000_0480;
    step();
    clr();
    step();
    outs("prio", 1'b0, 1'b1, 1'b1);
    chk("prio.pc", redir_pc, 32'h0000_0400);
    step();
    step();

    br_early_req = 1'b1;
    br_early_pc = 32'h0000_0600;
    step();
    outs("fsus", 1'b0, 1'b1, 1'b1);
    clr();
    iready_n = 1'b1;
    step();
    step();
    outs("fsus.hold", 1'b1, 1'b1, 1'b0);
    clr();
    step();
    outs("fsus.res", 1'b0, 1'b1, 1'b0);
    step();
    outs("fsus.run", 1'b0, 1'b0, 1'b0);

    iready_n = 1'b1;
    br_late_req = 1'b1;
    br_late_pc = 32'h0000_0700;
    step();
    rst = 1'b1;
    step();
    outs("rstw", 1'b0, 1'b1, 1'b0);
    chk("rstw.pc", redir_pc, 32'h0001_0000);
    rst = 1'b0;
    clr();
    step();
    outs("rstw.after", 1'b0, 1'b0, 1'b0);
    chk("rstw.after.pc", redir_pc, 32'h0001_0000);

    iready_n = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    chk("sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
    step();
    chk("sat.hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
    clr();
    step();
    outs("sat.exit", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
